// File: rtl/mod_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package mod_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_WIDTH = 64;

    // Quotient reported on divide-by-zero; sliced to WIDTH at the use site.
    localparam logic [MAX_WIDTH-1:0] DIVZERO_Q = '1;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/mod_div_seq_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface mod_div_seq_if #(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     dividend;
    logic [DIV_WIDTH-1:0] divisor;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     quotient;
    logic [DIV_WIDTH-1:0] remainder;
    logic                 div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/mod_div_step.sv
// One combinational restoring-division step: shift in a bit, subtract if it fits.
module mod_div_step #(
    parameter int DIV_WIDTH = 8
) (
    input  logic [DIV_WIDTH-1:0] rem_in,
    input  logic                 bit_in,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic [DIV_WIDTH-1:0] rem_out,
    output logic                 q_bit
);
    logic [DIV_WIDTH:0]   partial;
    logic [DIV_WIDTH-1:0] diff;

    always_comb begin
        partial = {rem_in, bit_in};
        // Low bits of the subtraction are exact whenever the subtraction is taken.
        diff    = partial[DIV_WIDTH-1:0] - divisor;
        q_bit   = (partial >= {1'b0, divisor});
        rem_out = q_bit ? diff : partial[DIV_WIDTH-1:0];
    end
endmodule

// File: rtl/mod_div_seq.sv
// Sequential unsigned divider: one restoring step per clock, quotient and remainder
// published together with a one-cycle done pulse.
module mod_div_seq
    import mod_div_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 8
) (
    input  logic          clock,
    input  logic          reset,
    mod_div_seq_if.slave  bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t               state;
    logic [CW-1:0]        count;
    logic [WIDTH-1:0]     shreg;      // dividend bits out at the top, quotient bits in at the bottom
    logic [DIV_WIDTH-1:0] prem;
    logic [DIV_WIDTH-1:0] dvsr;
    logic [DIV_WIDTH-1:0] rem_next;
    logic                 q_bit;

    mod_div_step #(.DIV_WIDTH(DIV_WIDTH)) u_step (
        .rem_in  (prem),
        .bit_in  (shreg[WIDTH-1]),
        .divisor (dvsr),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    // NOTE: every register here is a plain flop (no memory array), so all of them are
    // cleared by the async reset; state updates use non-blocking assignments only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            count           <= '0;
            shreg           <= '0;
            prem            <= '0;
            dvsr            <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        shreg <= bus.dividend;
                        dvsr  <= bus.divisor;
                        prem  <= '0;
                        if (bus.divisor == '0) begin
                            state           <= DONE;
                            bus.busy        <= 1'b0;
                            bus.done        <= 1'b1;
                            bus.quotient    <= DIVZERO_Q[WIDTH-1:0];
                            bus.remainder   <= bus.dividend[DIV_WIDTH-1:0];
                            bus.div_by_zero <= 1'b1;
                        end else begin
                            state    <= RUN;
                            count    <= CW'(WIDTH - 1);
                            bus.busy <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    shreg <= {shreg[WIDTH-2:0], q_bit};
                    prem  <= rem_next;
                    if (count == '0) begin
                        state           <= DONE;
                        bus.busy        <= 1'b0;
                        bus.done        <= 1'b1;
                        bus.quotient    <= {shreg[WIDTH-2:0], q_bit};
                        bus.remainder   <= rem_next;
                        bus.div_by_zero <= 1'b0;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mod_div_seq.sv
// Self-checking bench for mod_div_seq: directed vector table, protocol corner cases,
// and random sweeps for WIDTH=8/DIV_WIDTH=8 and WIDTH=16/DIV_WIDTH=4.
module tb_mod_div_seq;

    logic clock = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clock = ~clock;

    mod_div_seq_if #(.WIDTH(8),  .DIV_WIDTH(8)) bus8  ();
    mod_div_seq_if #(.WIDTH(16), .DIV_WIDTH(4)) bus16 ();

    mod_div_seq #(.WIDTH(8),  .DIV_WIDTH(8)) dut8  (.clock(clock), .reset(reset), .bus(bus8));
    mod_div_seq #(.WIDTH(16), .DIV_WIDTH(4)) dut16 (.clock(clock), .reset(reset), .bus(bus16));

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int z;
        int lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic cur_done(input bit big);
        return big ? bus16.done : bus8.done;
    endfunction

    function automatic logic cur_busy(input bit big);
        return big ? bus16.busy : bus8.busy;
    endfunction

    // Reference: plain integer division with the divide-by-zero convention.
    task automatic model(input int w, input int dw, input int a, input int b,
                         output int q, output int r, output int z, output int lat);
        if (b == 0) begin
            q = (1 << w) - 1;
            r = a % (1 << dw);
            z = 1;
            lat = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
            lat = w + 1;
        end
    endtask

    // Issue one operation and wait (bounded) for done; lat counts cycles after the accepting edge.
    task automatic do_op(input bit big, input logic [15:0] a, input logic [7:0] b,
                         output int q, output int r, output int z,
                         output int lat, output int nbusy, output int nboth);
        if (big) begin
            bus16.dividend = a;
            bus16.divisor  = b[3:0];
            bus16.start    = 1'b1;
        end else begin
            bus8.dividend = a[7:0];
            bus8.divisor  = b;
            bus8.start    = 1'b1;
        end
        tick();
        bus8.start  = 1'b0;
        bus16.start = 1'b0;
        lat   = 1;
        nbusy = 0;
        nboth = 0;
        while (!cur_done(big) && lat < 100) begin
            if (cur_busy(big)) nbusy++;
            tick();
            lat++;
        end
        if (cur_busy(big) && cur_done(big)) nboth++;
        q = big ? int'(bus16.quotient)    : int'(bus8.quotient);
        r = big ? int'(bus16.remainder)   : int'(bus8.remainder);
        z = big ? int'(bus16.div_by_zero) : int'(bus8.div_by_zero);
    endtask

    initial begin
        int q, r, z, lat, nbusy, nboth, ndone;
        int eq, er, ez, elat;
        int a, b;

        vecs[0] = '{237, 10, 23,  7,   0, 9};
        vecs[1] = '{100, 10, 10,  0,   0, 9};
        vecs[2] = '{5,   10, 0,   5,   0, 9};
        vecs[3] = '{255, 1,  255, 0,   0, 9};
        vecs[4] = '{250, 0,  255, 250, 1, 1};
        vecs[5] = '{9,   3,  3,   0,   0, 9};
        vecs[6] = '{0,   7,  0,   0,   0, 9};
        vecs[7] = '{255, 255, 1,  0,   0, 9};
        vecs[8] = '{1,   255, 0,  1,   0, 9};

        bus8.start = 1'b0;  bus8.dividend = '0;  bus8.divisor = '0;
        bus16.start = 1'b0; bus16.dividend = '0; bus16.divisor = '0;
        reset = 1'b1;
        #2;
        check("rst_q8",    bus8.quotient,     0);
        check("rst_r8",    bus8.remainder,    0);
        check("rst_busy8", bus8.busy,         0);
        check("rst_done8", bus8.done,         0);
        check("rst_z8",    bus8.div_by_zero,  0);
        check("rst_q16",   bus16.quotient,    0);
        check("rst_busy16", bus16.busy,       0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            do_op(1'b0, 16'(vecs[i].a), 8'(vecs[i].b), q, r, z, lat, nbusy, nboth);
            check($sformatf("vec%0d_q", i),    q,     vecs[i].q);
            check($sformatf("vec%0d_r", i),    r,     vecs[i].r);
            check($sformatf("vec%0d_z", i),    z,     vecs[i].z);
            check($sformatf("vec%0d_lat", i),  lat,   vecs[i].lat);
            check($sformatf("vec%0d_busy", i), nbusy, vecs[i].lat - 1);
            check($sformatf("vec%0d_both", i), nboth, 0);
            tick();
        end

        // Start pulsed during RUN is ignored; results hold during RUN and after done
        bus8.dividend = 8'd200; bus8.divisor = 8'd7; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        tick();
        tick();
        check("run_busy",      bus8.busy,      1);
        check("run_hold_q",    bus8.quotient,  0);
        check("run_hold_r",    bus8.remainder, 1);
        bus8.dividend = 8'd100; bus8.divisor = 8'd3; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus8.done) ndone++;
            tick();
        end
        check("ign_ndone", ndone,          1);
        check("ign_q",     bus8.quotient,  28);
        check("ign_r",     bus8.remainder, 4);
        check("ign_idle",  bus8.busy,      0);

        // Start held high through DONE: back-to-back second operation
        bus8.dividend = 8'd237; bus8.divisor = 8'd10; bus8.start = 1'b1;
        tick();
        lat = 1;
        while (!bus8.done && lat < 100) begin
            tick();
            lat++;
        end
        check("b2b_lat1", lat,            9);
        check("b2b_q1",   bus8.quotient,  23);
        check("b2b_r1",   bus8.remainder, 7);
        bus8.dividend = 8'd200; bus8.divisor = 8'd7;
        tick();
        bus8.start = 1'b0;
        check("b2b_restart_busy", bus8.busy, 1);
        check("b2b_restart_done", bus8.done, 0);
        lat = 1;
        while (!bus8.done && lat < 100) begin
            tick();
            lat++;
        end
        check("b2b_gap", lat,            9);
        check("b2b_q2",  bus8.quotient,  28);
        check("b2b_r2",  bus8.remainder, 4);
        tick();

        // Async reset between edges mid-RUN
        bus8.dividend = 8'd237; bus8.divisor = 8'd10; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        tick();
        tick();
        tick();
        #3 reset = 1'b1;
        #1;
        check("arst_q",    bus8.quotient,    0);
        check("arst_r",    bus8.remainder,   0);
        check("arst_busy", bus8.busy,        0);
        check("arst_done", bus8.done,        0);
        check("arst_z",    bus8.div_by_zero, 0);
        tick();
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus8.done || bus8.busy) ndone++;
            tick();
        end
        check("arst_no_done", ndone, 0);
        do_op(1'b0, 16'd200, 8'd7, q, r, z, lat, nbusy, nboth);
        check("arst_after_q",   q,   28);
        check("arst_after_r",   r,   4);
        check("arst_after_lat", lat, 9);
        tick();

        // Wide configuration
        do_op(1'b1, 16'd65535, 8'd15, q, r, z, lat, nbusy, nboth);
        check("w16_q",    q,     4369);
        check("w16_r",    r,     0);
        check("w16_z",    z,     0);
        check("w16_lat",  lat,   17);
        check("w16_busy", nbusy, 16);
        tick();

        // Random sweeps against the reference model
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            model(8, 8, a, b, eq, er, ez, elat);
            do_op(1'b0, 16'(a), 8'(b), q, r, z, lat, nbusy, nboth);
            check($sformatf("rnd8_q %0d/%0d", a, b),   q,   eq);
            check($sformatf("rnd8_r %0d/%0d", a, b),   r,   er);
            check($sformatf("rnd8_z %0d/%0d", a, b),   z,   ez);
            check($sformatf("rnd8_lat %0d/%0d", a, b), lat, elat);
            if ($urandom_range(0, 1) == 1) tick();
        end
        for (int i = 0; i < 30; i++) begin
            a = int'($urandom_range(0, 65535));
            b = int'($urandom_range(0, 15));
            model(16, 4, a, b, eq, er, ez, elat);
            do_op(1'b1, 16'(a), 8'(b), q, r, z, lat, nbusy, nboth);
            check($sformatf("rnd16_q %0d/%0d", a, b),   q,   eq);
            check($sformatf("rnd16_r %0d/%0d", a, b),   r,   er);
            check($sformatf("rnd16_z %0d/%0d", a, b),   z,   ez);
            check($sformatf("rnd16_lat %0d/%0d", a, b), lat, elat);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
